// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - in-order register-file writeback queue; pending-write bypass built only when WBQ_BYPASS_EN is defined
module regfile_writeback_queue #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ADDR_W-1:0]      in_rd,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   wb_hold,
   output logic                   wb_we,
   output logic [ADDR_W-1:0]      wb_addr,
   output logic [DATA_W-1:0]      wb_data,
`ifdef WBQ_BYPASS_EN
   input  logic [ADDR_W-1:0]      lk_rs,
   output logic                   lk_hit,
   output logic [DATA_W-1:0]      lk_data,
`endif
   output logic [$clog2(DEPTH):0] pending
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Entry storage: destination register and value, indexed by circular pointer
   logic [ADDR_W-1:0] ent_rd   [DEPTH];
   logic [DATA_W-1:0] ent_data [DEPTH];

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;

   logic              empty;
   logic              full;
   logic              accept;
   logic              store;
   logic              pop;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

   // A full queue can still accept when the head drains on the same edge
   assign in_ready = !rst && (!full || !wb_hold);

   // Write port is driven whenever something is queued and the port is not borrowed
   assign wb_we    = !empty && !wb_hold && !rst;
   assign wb_addr  = (empty || rst) ? '0 : ent_rd[head];
   assign wb_data  = (empty || rst) ? '0 : ent_data[head];

   // x0 writes complete the handshake but are never stored
   assign accept   = in_valid && in_ready;
   assign store    = accept && (in_rd != '0);
   assign pop      = wb_we;

   assign pending  = count;

   // Pointer and occupancy bookkeeping; reset discards every queued write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (store) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({store, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry payload capture at the tail; contents are only meaningful while counted
   always_ff @(posedge clk) begin
      if (store) begin
         ent_rd[tail]   <= in_rd;
         ent_data[tail] <= in_data;
      end
   end

`ifdef WBQ_BYPASS_EN
   logic [PTR_W-1:0] scan_idx;

   // Scan oldest to youngest so a later match overrides an earlier one
   always_comb begin
      lk_hit   = 1'b0;
      lk_data  = '0;
      scan_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head + PTR_W'(i);
         if ((CNT_W'(i) < count) && (lk_rs != '0) && (ent_rd[scan_idx] == lk_rs)) begin
            lk_hit  = 1'b1;
            lk_data = ent_data[scan_idx];
         end
      end
   end
`else
   // No lookup path: decode must stall on source conflicts while pending != 0
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - self-checking bench for regfile_writeback_queue
module tb_regfile_writeback_queue;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_rd;
   logic [DATA_W-1:0] in_data;
   logic              wb_hold;
   logic              wb_we;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [2:0]        pending;
`ifdef WBQ_BYPASS_EN
   logic [ADDR_W-1:0] lk_rs;
   logic              lk_hit;
   logic [DATA_W-1:0] lk_data;
`endif

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int cyc    = 0;

   typedef struct {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } ent_t;

   typedef struct {
      int                cyc;
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } com_t;

   ent_t mq[$];
   com_t log_q[$];

   regfile_writeback_queue #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_rd   (in_rd),
      .in_data (in_data),
      .wb_hold (wb_hold),
      .wb_we   (wb_we),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
`ifdef WBQ_BYPASS_EN
      .lk_rs   (lk_rs),
      .lk_hit  (lk_hit),
      .lk_data (lk_data),
`endif
      .pending (pending)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference rules, expressed on the model queue
   function automatic logic m_we();
      return (mq.size() != 0) && !wb_hold && !rst;
   endfunction

   function automatic logic m_ready();
      return !rst && ((mq.size() < DEPTH) || !wb_hold);
   endfunction

   function automatic logic [DATA_W:0] m_lookup(input logic [ADDR_W-1:0] rs);
      logic [DATA_W:0] r;
      r = '0;
      if (rs != 0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == rs) begin
               r = {1'b1, mq[i].data};
               break;
            end
         end
      end
      return r;
   endfunction

   // Model state update at the same edges the design sees
   always @(posedge clk or posedge rst) begin
      logic acc;
      logic pop;
      ent_t e;
      if (rst) begin
         mq.delete();
      end else begin
         acc = in_valid && m_ready();
         pop = m_we();
         if (pop) void'(mq.pop_front());
         if (acc && (in_rd != 0)) begin
            e.rd   = in_rd;
            e.data = in_data;
            mq.push_back(e);
         end
      end
   end

   // Per-cycle comparison at the register-file sample point; also records commits
   always @(negedge clk) begin
      com_t c;
      logic [DATA_W:0] lk;
      if (chk_en) begin
         check("cmp_wb_we",    wb_we,    m_we());
         check("cmp_wb_addr",  wb_addr,  (mq.size() != 0 && !rst) ? mq[0].rd   : '0);
         check("cmp_wb_data",  wb_data,  (mq.size() != 0 && !rst) ? mq[0].data : '0);
         check("cmp_pending",  pending,  mq.size());
         check("cmp_in_ready", in_ready, m_ready());
`ifdef WBQ_BYPASS_EN
         lk = m_lookup(lk_rs);
         check("cmp_lk_hit",  lk_hit,  lk[DATA_W]);
         check("cmp_lk_data", lk_data, lk[DATA_W-1:0]);
`else
         lk = m_lookup('0);
         check("cmp_model_x0_nohit", lk, '0);
`endif
         if (wb_we) begin
            c.cyc  = cyc;
            c.rd   = wb_addr;
            c.data = wb_data;
            log_q.push_back(c);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (pending != 0 && n < 30) begin
         step();
         n++;
      end
      check("drain_timeout", pending, 0);
   endtask

   task automatic check_log(input string nm, input int rds[$]);
      check({nm, "_len"}, log_q.size(), rds.size());
      for (int i = 0; i < rds.size(); i++) begin
         if (i < log_q.size()) begin
            check({nm, "_rd"},   log_q[i].rd,   rds[i]);
            check({nm, "_data"}, log_q[i].data, 32'hA000 + rds[i]);
            if (i > 0) check({nm, "_consecutive"}, log_q[i].cyc - log_q[i-1].cyc, 1);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_rd    = '0;
      in_data  = '0;
      wb_hold  = 1'b0;
`ifdef WBQ_BYPASS_EN
      lk_rs    = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("rst_wb_we",    wb_we,    0);
      check("rst_in_ready", in_ready, 0);
      check("rst_pending",  pending,  0);
      check("rst_wb_addr",  wb_addr,  0);
      check("rst_wb_data",  wb_data,  0);
      rst = 1'b0;

      // Single write: presented the cycle after acceptance, gone the cycle after
      in_valid = 1'b1; in_rd = 5; in_data = 32'hDEADBEEF;
      step();
      in_valid = 1'b0;
      check("single_we",      wb_we,   1);
      check("single_addr",    wb_addr, 5);
      check("single_data",    wb_data, 32'hDEADBEEF);
      check("single_pending", pending, 1);
      step();
      check("single_pending_after", pending, 0);
      check("single_we_after",      wb_we,   0);

      // x0 write: handshake completes, nothing stored
      in_valid = 1'b1; in_rd = 0; in_data = 32'h1234;
      #1;
      check("x0_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("x0_pending", pending, 0);
      check("x0_we",      wb_we,   0);
      step();
      check("x0_pending2", pending, 0);

      // Fill under hold, then release with a simultaneous accept and drain
      wb_hold = 1'b1;
      for (int r = 1; r <= 4; r++) begin
         in_valid = 1'b1; in_rd = ADDR_W'(r); in_data = 32'hA000 + r;
         step();
      end
      in_valid = 1'b0;
      check("fill_pending", pending, 4);
      check("fill_we",      wb_we,   0);
      log_q.delete();
      in_valid = 1'b1; in_rd = 7; in_data = 32'hA007;
      #1;
      check("full_ready", in_ready, 0);
      step();
      check("full_reject_pending", pending, 4);
      wb_hold = 1'b0;
      #1;
      check("full_release_ready", in_ready, 1);
      check("full_release_we",    wb_we,    1);
      step();
      in_valid = 1'b0;
      check("full_swap_pending", pending, 4);
      wait_drain();
      check_log("order_fill", '{1, 2, 3, 4, 7});

`ifdef WBQ_BYPASS_EN
      // Bypass: youngest matching entry wins; same-edge data not yet visible
      wb_hold = 1'b1;
      in_valid = 1'b1; in_rd = 3; in_data = 32'h11;
      step();
      in_rd = 3; in_data = 32'h22; lk_rs = 3;
      #1;
      check("byp_first_hit",  lk_hit,  1);
      check("byp_first_data", lk_data, 32'h11);
      step();
      in_valid = 1'b0;
      #1;
      check("byp_young_hit",  lk_hit,  1);
      check("byp_young_data", lk_data, 32'h22);
      lk_rs = 9;
      #1;
      check("byp_miss_hit",  lk_hit,  0);
      check("byp_miss_data", lk_data, 0);
      lk_rs = 0;
      #1;
      check("byp_x0_hit", lk_hit, 0);
      lk_rs = 3; wb_hold = 1'b0;
      #1;
      check("byp_head_hit",  lk_hit,  1);
      check("byp_head_data", lk_data, 32'h22);
      wait_drain();
      check("byp_drained_hit", lk_hit, 0);
      lk_rs = 0;
`endif

      // Reset between edges while draining
      wb_hold = 1'b1;
      for (int r = 10; r <= 12; r++) begin
         in_valid = 1'b1; in_rd = ADDR_W'(r); in_data = 32'hA000 + r;
         step();
      end
      in_valid = 1'b0;
      check("mid_rst_pending_before", pending, 3);
      wb_hold = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_we",       wb_we,    0);
      check("mid_rst_pending",  pending,  0);
      check("mid_rst_ready",    in_ready, 0);
      check("mid_rst_addr",     wb_addr,  0);
      log_q.delete();
      step();
      rst = 1'b0;
      repeat (4) step();
      check("post_rst_no_stale", log_q.size(), 0);
      check("post_rst_ready",    in_ready,     1);
      check("post_rst_pending",  pending,      0);

      // Back-to-back stream across several pointer wraps
      log_q.delete();
      wb_hold = 1'b0;
      for (int r = 1; r <= 10; r++) begin
         in_valid = 1'b1; in_rd = ADDR_W'(r); in_data = 32'hA000 + r;
         step();
         check("wrap_pending_le1", pending <= 1, 1);
      end
      in_valid = 1'b0;
      wait_drain();
      check_log("order_wrap", '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
